// File: rtl/nums_pkg.sv
// Shared constants, types and the 55x5 digit-strip bitmap for the numeric overlay.
// Strip bit index = row*55 + glyph*5 + col; glyph 10 is blank.
package nums_pkg;

    localparam int GLYPH_W    = 5;
    localparam int GLYPH_H    = 5;
    localparam int STRIP_W    = 55;
    localparam int NUM_GLYPHS = 11;
    localparam logic [3:0] GLYPH_BLANK = 4'd10;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    // Rows top to bottom, leftmost pixel in the MSB of each 5-bit row.
    function automatic logic [24:0] glyph_bits(input logic [3:0] g);
        logic [24:0] b;
        case (g)
            4'd0:    b = 25'b01110_10001_10001_10001_01110;
            4'd1:    b = 25'b00100_01100_00100_00100_01110;
            4'd2:    b = 25'b11110_00001_01110_10000_11111;
            4'd3:    b = 25'b11110_00001_01110_00001_11110;
            4'd4:    b = 25'b10010_10010_11111_00010_00010;
            4'd5:    b = 25'b11111_10000_11110_00001_11110;
            4'd6:    b = 25'b01110_10000_11110_10001_01110;
            4'd7:    b = 25'b11111_00001_00010_00100_00100;
            4'd8:    b = 25'b01110_10001_01110_10001_01110;
            4'd9:    b = 25'b01110_10001_01111_00001_01110;
            default: b = 25'b0;
        endcase
        return b;
    endfunction

    function automatic logic [511:0] build_strip();
        logic [511:0] s;
        logic [24:0]  gb;
        s = '0;
        for (int g = 0; g < NUM_GLYPHS; g++) begin
            gb = glyph_bits(4'(g));
            for (int r = 0; r < GLYPH_H; r++) begin
                for (int c = 0; c < GLYPH_W; c++) begin
                    s[9'(r * STRIP_W + g * GLYPH_W + c)] = gb[5'(24 - (r * GLYPH_W + c))];
                end
            end
        end
        return s;
    endfunction

    localparam logic [511:0] STRIP_BITS = build_strip();

endpackage

// File: rtl/nums_bin2bcd.sv
// Sequential double-dabble: VALUE_W shift cycles plus one commit cycle, saturating at all-9s.
// Leading-zero blanking at commit when NUMS_LEADING_ZERO_BLANK_EN is defined.
module nums_bin2bcd
    import nums_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int VALUE_W    = 14
) (
    input  logic                        vga_clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [VALUE_W-1:0]          bin,
    output logic                        busy,
    output logic                        done,
    output bcd_t [NUM_DIGITS-1:0]       digits
);

    // Scratch is wide enough for any VALUE_W input so overflow is visible as upper nibbles.
    localparam int FULL_N = (VALUE_W + 2) / 3;
    localparam int BCD_N  = (FULL_N > NUM_DIGITS) ? FULL_N : NUM_DIGITS;
    localparam int CNT_W  = $clog2(VALUE_W + 1);

`ifdef NUMS_LEADING_ZERO_BLANK_EN
    localparam bcd_t [NUM_DIGITS-1:0] DIGITS_RST = {{(NUM_DIGITS-1){GLYPH_BLANK}}, 4'd0};
`else
    localparam bcd_t [NUM_DIGITS-1:0] DIGITS_RST = '0;
`endif

    state_t                state_q, state_d;
    logic [VALUE_W-1:0]    bin_q, bin_d;
    logic [BCD_N*4-1:0]    bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    bcd_t [NUM_DIGITS-1:0] digits_q, digits_d, commit_digits;
    logic                  ovf, leading;

    always_comb begin
        for (int i = 0; i < BCD_N; i++) begin
            bcd_adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3 : bcd_q[i*4 +: 4];
        end
    end

    always_comb begin
        ovf = 1'b0;
        for (int i = NUM_DIGITS; i < BCD_N; i++) begin
            ovf = ovf | (bcd_q[i*4 +: 4] != 4'd0);
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            commit_digits[i] = ovf ? 4'd9 : bcd_q[i*4 +: 4];
        end
        leading = 1'b1;
`ifdef NUMS_LEADING_ZERO_BLANK_EN
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (leading && commit_digits[i] == 4'd0) begin
                commit_digits[i] = GLYPH_BLANK;
            end else begin
                leading = 1'b0;
            end
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        digits_d = digits_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d   = bin;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d          = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(VALUE_W - 1)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                digits_d = commit_digits;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            digits_q <= DIGITS_RST;
        end else begin
            state_q  <= state_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
        end
    end

    assign busy   = (state_q == SHIFT);
    assign done   = (state_q == COMMIT);
    assign digits = digits_q;

endmodule

// File: rtl/nums_rom.sv
// 1-bit digit-strip ROM, read on the falling edge so data is ready at the next rising edge.
module nums_rom
    import nums_pkg::*;
(
    input  logic       vga_clk,
    input  logic [8:0] addr,
    output logic       q
);

    always_ff @(negedge vga_clk) begin
        q <= STRIP_BITS[addr];
    end

endmodule

// File: rtl/nums_display.sv
// Decimal overlay: value latched on LATCH_LINE, converted to BCD, drawn as scaled glyphs.
// Pixel path latency 2 vga_clk; optional leading-zero blanking via NUMS_LEADING_ZERO_BLANK_EN.
module nums_display
    import nums_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int VALUE_W    = 14,
    parameter int SCALE_LOG2 = 2,
    parameter int LATCH_LINE = 480
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    input  logic               blank,
    input  logic [VALUE_W-1:0] value,
    input  logic [9:0]         pos_x,
    input  logic [9:0]         pos_y,
    input  logic [11:0]        fg_rgb,
    output logic               pixel_on,
    output logic [3:0]         red,
    output logic [3:0]         green,
    output logic [3:0]         blue,
    output logic               busy
);

    localparam int BOX_W = (NUM_DIGITS * GLYPH_W) << SCALE_LOG2;
    localparam int BOX_H = GLYPH_H << SCALE_LOG2;

    bcd_t [NUM_DIGITS-1:0] digits;
    logic                  conv_busy, conv_done, conv_start;

    // Only offer a trigger while the converter is idle.
    assign conv_start = (DrawY == 10'(LATCH_LINE)) && (DrawX == 10'd0) && !conv_busy && !conv_done;

    nums_bin2bcd #(
        .NUM_DIGITS(NUM_DIGITS),
        .VALUE_W   (VALUE_W)
    ) u_bin2bcd (
        .vga_clk(vga_clk),
        .reset_n(reset_n),
        .start  (conv_start),
        .bin    (value),
        .busy   (conv_busy),
        .done   (conv_done),
        .digits (digits)
    );

    assign busy = conv_busy;

    logic [9:0]  lx, ly, gx, gy, slot, col;
    logic        in_box_d;
    bcd_t        glyph;
    logic [8:0]  rom_addr_d;

    always_comb begin
        lx       = DrawX - pos_x;
        ly       = DrawY - pos_y;
        in_box_d = (DrawX >= pos_x) && (DrawY >= pos_y) &&
                   (lx < 10'(BOX_W)) && (ly < 10'(BOX_H));
        gx       = lx >> SCALE_LOG2;
        gy       = ly >> SCALE_LOG2;
        slot     = gx / 10'(GLYPH_W);
        col      = gx - slot * 10'(GLYPH_W);
        glyph    = GLYPH_BLANK;
        for (int s = 0; s < NUM_DIGITS; s++) begin
            if (slot == 10'(s)) begin
                glyph = digits[NUM_DIGITS-1-s];
            end
        end
        rom_addr_d = 9'(gy * 10'(STRIP_W) + {6'd0, glyph} * 10'(GLYPH_W) + col);
    end

    logic [8:0]  rom_addr_q;
    logic        in_box_q, blank_q, rom_q;
    logic        pixel_on_d, pixel_on_q;
    logic [11:0] rgb_d, rgb_q;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr_q <= '0;
            in_box_q   <= 1'b0;
            blank_q    <= 1'b0;
        end else begin
            rom_addr_q <= rom_addr_d;
            in_box_q   <= in_box_d;
            blank_q    <= blank;
        end
    end

    nums_rom u_rom (
        .vga_clk(vga_clk),
        .addr   (rom_addr_q),
        .q      (rom_q)
    );

    assign pixel_on_d = in_box_q & blank_q & rom_q;
    assign rgb_d      = pixel_on_d ? fg_rgb : 12'h000;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            pixel_on_q <= 1'b0;
            rgb_q      <= '0;
        end else begin
            pixel_on_q <= pixel_on_d;
            rgb_q      <= rgb_d;
        end
    end

    assign pixel_on           = pixel_on_q;
    assign {red, green, blue} = rgb_q;

endmodule

// File: tb/tb_nums_display.sv
// Randomised scoreboard bench for nums_display against an arithmetic reference model.
module tb_nums_display;

    localparam int ND    = 4;
    localparam int VW    = 14;
    localparam int SL    = 2;
    localparam int BOX_W = ND * 5 * (1 << SL);
    localparam int BOX_H = 5 * (1 << SL);

    logic          vga_clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [9:0]    DrawX   = '0;
    logic [9:0]    DrawY   = '0;
    logic          blank   = 1'b0;
    logic [VW-1:0] value   = '0;
    logic [9:0]    pos_x   = '0;
    logic [9:0]    pos_y   = '0;
    logic [11:0]   fg_rgb  = '0;
    logic          pixel_on;
    logic [3:0]    red, green, blue;
    logic          busy;

    always #5 vga_clk = ~vga_clk;

    nums_display #(
        .NUM_DIGITS(ND),
        .VALUE_W   (VW),
        .SCALE_LOG2(SL),
        .LATCH_LINE(480)
    ) dut (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .DrawX   (DrawX),
        .DrawY   (DrawY),
        .blank   (blank),
        .value   (value),
        .pos_x   (pos_x),
        .pos_y   (pos_y),
        .fg_rgb  (fg_rgb),
        .pixel_on(pixel_on),
        .red     (red),
        .green   (green),
        .blue    (blue),
        .busy    (busy)
    );

    // Reference font, rows top to bottom, leftmost pixel first.
    logic [24:0] FONT [10] = '{
        25'b01110_10001_10001_10001_01110,
        25'b00100_01100_00100_00100_01110,
        25'b11110_00001_01110_10000_11111,
        25'b11110_00001_01110_00001_11110,
        25'b10010_10010_11111_00010_00010,
        25'b11111_10000_11110_00001_11110,
        25'b01110_10000_11110_10001_01110,
        25'b11111_00001_00010_00100_00100,
        25'b01110_10001_01110_10001_01110,
        25'b01110_10001_01111_00001_01110
    };

    typedef struct {
        int          due;
        logic        on;
        logic [11:0] rgb;
        int          x;
        int          y;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   shown[ND];
    int   cyc         = 0;
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic int pow10(int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic void set_shown(int v);
        int sat;
        sat = (v > pow10(ND) - 1) ? pow10(ND) - 1 : v;
        for (int s = 0; s < ND; s++) shown[s] = (sat / pow10(ND - 1 - s)) % 10;
`ifdef NUMS_LEADING_ZERO_BLANK_EN
        for (int s = 0; s < ND - 1; s++) begin
            if (shown[s] != 0) break;
            shown[s] = 10;
        end
`endif
    endfunction

    function automatic logic model_pixel(int x, int y, logic b);
        int lx, ly, gx, gy, slot, col;
        logic [24:0] f;
        lx = x - int'(pos_x);
        ly = y - int'(pos_y);
        if (!b || lx < 0 || ly < 0 || lx >= BOX_W || ly >= BOX_H) return 1'b0;
        gx   = lx / (1 << SL);
        gy   = ly / (1 << SL);
        slot = gx / 5;
        col  = gx % 5;
        if (shown[slot] == 10) return 1'b0;
        f = FONT[shown[slot]];
        return f[5'(24 - (gy * 5 + col))];
    endfunction

    task automatic check(string name, int got, int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic drive_px(int x, int y, logic b);
        logic on;
        @(negedge vga_clk);
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = b;
        on    = model_pixel(x, y, b);
        sbq.push_back('{cyc + 2, on, on ? fg_rgb : 12'h000, x, y});
    endtask

    task automatic scan(int x0, int x1, int y0, int y1, bit rnd);
        logic b;
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++) begin
                b = (x < 640) && (y < 480);
                if (rnd && $urandom_range(0, 7) == 0) b = 1'b0;
                drive_px(x, y, b);
            end
        end
    endtask

    task automatic do_latch(int v, bit retrig);
        int nbusy;
        nbusy = 0;
        value = VW'(v);
        drive_px(0, 480, 1'b0);
        set_shown(v);
        for (int i = 1; i < 30; i++) begin
            if (retrig && i == 3) begin
                value = VW'(1);
                drive_px(0, 480, 1'b0);
            end else begin
                drive_px(i, 480, 1'b0);
            end
            if (busy) nbusy++;
        end
        check("busy_cycles", nbusy, VW);
    endtask

    always @(posedge vga_clk) begin
        #1;
        cyc = cyc + 1;
        while (reset_n && sbq.size() > 0 && sbq[0].due <= cyc) begin
            mon_e = sbq.pop_front();
            vectors++;
            if (mon_e.due != cyc || pixel_on !== mon_e.on || {red, green, blue} !== mon_e.rgb) begin
                miscompares++;
                $display("FAIL pixel (%0d,%0d) cyc %0d: got on=%b rgb=%h, expected on=%b rgb=%h",
                         mon_e.x, mon_e.y, cyc, pixel_on, {red, green, blue}, mon_e.on, mon_e.rgb);
            end
        end
    end

    initial begin
        #50_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int px, py;
        #2 reset_n = 1'b0;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_pixel_on", int'(pixel_on), 0);
        check("rst_rgb", int'({red, green, blue}), 0);
        set_shown(0);
        repeat (3) @(negedge vga_clk);
        reset_n = 1'b1;

        pos_x  = 10'd100;
        pos_y  = 10'd200;
        fg_rgb = 12'hF00;
        scan(98, 181, 198, 203, 1'b0);

        do_latch(1234, 1'b0);
        scan(98, 181, 198, 221, 1'b0);

        do_latch(12345, 1'b1);
        scan(98, 181, 198, 221, 1'b1);

        do_latch(5, 1'b0);
        scan(98, 181, 198, 209, 1'b0);
        value = VW'(7);
        scan(98, 181, 210, 221, 1'b0);
        do_latch(7, 1'b0);
        scan(98, 181, 198, 221, 1'b0);

        // Reset in the middle of a conversion.
        value = VW'(8888);
        drive_px(0, 480, 1'b0);
        for (int i = 1; i <= 6; i++) drive_px(i, 480, 1'b0);
        #2 reset_n = 1'b0;
        sbq.delete();
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_pixel_on", int'(pixel_on), 0);
        check("midrst_rgb", int'({red, green, blue}), 0);
        set_shown(0);
        repeat (2) @(negedge vga_clk);
        reset_n = 1'b1;
        scan(98, 181, 198, 221, 1'b0);
        do_latch(42, 1'b0);
        scan(98, 181, 198, 221, 1'b1);

        // Box hanging off the bottom-right corner.
        pos_x  = 10'd630;
        pos_y  = 10'd470;
        fg_rgb = 12'h0F0;
        do_latch(8888, 1'b0);
        scan(620, 660, 460, 490, 1'b0);

        repeat (3) begin
            px     = $urandom_range(2, 620);
            py     = $urandom_range(2, 470);
            pos_x  = 10'(px);
            pos_y  = 10'(py);
            fg_rgb = 12'($urandom_range(1, 4095));
            do_latch($urandom_range(0, 16383), 1'b0);
            scan(px - 2, px + BOX_W + 1, py - 2, py + BOX_H + 1, 1'b1);
        end

        repeat (4) @(negedge vga_clk);
        check("drain", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nums_display.md
Name: nums_display

Overview:
- Renders an unsigned binary value as NUM_DIGITS decimal digits from the shared 1-bit digit-strip ROM, for score and timer overlays.
- The strip is 11 glyphs of 5x5 pixels, 55x5 pixels in total. Glyphs 0-9 are the digits; glyph 10 is blank.
- Each frame, it converts the value to BCD during vertical blanking with a sequential double-dabble FSM.
- In the active area it draws a scaled digit box at a runtime position, through a 2-stage pixel pipeline. The video mux consumes the result.

Parameters:
- NUM_DIGITS, 4, number of decimal digits drawn; slot 0 is leftmost (most significant).
- VALUE_W, 14, width of the binary value input.
- SCALE_LOG2, 2, each glyph pixel is drawn as a 2^SCALE_LOG2 square.
- LATCH_LINE, 480, DrawY line on which the value is sampled.

Ports:
- vga_clk  in  1  pixel clock.
- reset_n  in  1  asynchronous active-low reset.
- DrawX  in  10  current pixel x.
- DrawY  in  10  current pixel y.
- blank  in  1  1 = active video.
- value  in  VALUE_W  binary number to display.
- pos_x  in  10  left edge of the digit box.
- pos_y  in  10  top edge of the digit box.
- fg_rgb  in  12  glyph colour, {r,g,b} 4 bits each.
- pixel_on  out  1  current output pixel is a lit glyph pixel.
- red  out  4  colour out.
- green  out  4  colour out.
- blue  out  4  colour out.
- busy  out  1  BCD conversion in progress.

Behaviour:
- Reset is asynchronous, active-low. All of the following clear immediately and stay clear until reset_n rises:
  - FSM goes to IDLE; busy=0.
  - digits register cleared to all 0.
  - pipeline registers cleared; pixel_on=0; red/green/blue=0.
- Conversion FSM: IDLE -> SHIFT -> COMMIT -> IDLE.
  - IDLE: on the posedge with DrawY==LATCH_LINE and DrawX==0, snapshot value into the shift register, clear the BCD scratch register, and go to SHIFT. busy=1 from the next cycle.
  - SHIFT: runs exactly VALUE_W cycles. Each cycle, add 3 to every BCD nibble >=5, then shift {bcd, bin} left 1. A counter tracks the cycles.
  - COMMIT: one cycle.
    - If the value exceeds 10^NUM_DIGITS-1 (BCD carry beyond NUM_DIGITS nibbles), load all digits with 9 (saturate).
    - Otherwise load the BCD nibbles into the digits register.
    - Then return to IDLE; busy=0.
- value changes after the snapshot are ignored until the next frame.
- A latch trigger while not IDLE is ignored.
- The digits register changes only in COMMIT, so the display never tears within a frame.
- Reset mid-conversion abandons the conversion; the digits register holds 0.
- Pixel pipeline, stage 1 (posedge):
  - lx = DrawX - pos_x and ly = DrawY - pos_y, both 10-bit.
  - in_box = (DrawX >= pos_x) && (DrawY >= pos_y) && (lx < NUM_DIGITS*5<<SCALE_LOG2) && (ly < 5<<SCALE_LOG2).
  - gx = lx>>SCALE_LOG2; gy = ly>>SCALE_LOG2.
  - slot = gx/5; col = gx - slot*5.
  - rom_addr (9 bits) = gy*55 + glyph*5 + col.
  - Register rom_addr, in_box and blank.
  - Boxes extending past x=639 or y=479 are clipped; there is no wrap.
- The ROM is clocked on ~vga_clk, so data is valid at the next posedge.
- Stage 2 (posedge):
  - pixel_on = in_box_d & blank_d & rom_q.
  - {red,green,blue} = pixel_on ? fg_rgb : 0.
- Latency: the output corresponds to DrawX/DrawY presented 2 vga_clk posedges earlier.

Optional Feature:
- Macro NUMS_LEADING_ZERO_BLANK_EN.
- Defined:
  - In COMMIT, leading zero digits are replaced by glyph 10 (blank).
  - The rightmost digit is never blanked, so value 0 shows a single "0" in the last slot.
  - After reset, all slots except the last are blank.
- Undefined: all digits are drawn, e.g. 0042.

Decomposition:
- Package nums_pkg holds:
  - GLYPH_W=5, GLYPH_H=5, STRIP_W=55, GLYPH_BLANK=4'd10.
  - typedef bcd_t (logic [3:0]).
  - FSM state enum {IDLE, SHIFT, COMMIT}.
- Sub-module nums_bin2bcd contains the FSM, scratch registers and saturation.
  - Ports: vga_clk, reset_n, start, bin, busy, done, digits.
  - nums_display instantiates nums_bin2bcd plus the existing nums_rom.

Test Plan:
- Reset released, value=1234, pos=(100,200), SCALE_LOG2=2, fg=12'hF00:
  - busy is high for 14 cycles after the DrawY=480/DrawX=0 edge.
  - Next frame, pixel_on matches the glyph bitmaps of 1,2,3,4 in an 80x20 box at (100,200).
  - Lit pixels are red F/0/0.
- value=12345 with NUM_DIGITS=4 -> the display shows 9999.
- value changed from 5 to 7 in mid-frame (DrawY=100):
  - The rest of that frame still shows 0005.
  - The following frame shows 0007.
  - With NUMS_LEADING_ZERO_BLANK_EN, it shows blank,blank,blank,7.
- reset_n pulsed low during SHIFT (cycle 6):
  - busy=0 and outputs are 0 immediately.
  - The next frame shows 0000 until the next latch completes.
- Box at pos=(630,470):
  - Pixels beyond 639/479 are not drawn.
  - No pixel is lit at x<630 or y<470.
- Single lit pixel at DrawX=pos_x, DrawY=pos_y: pixel_on asserts exactly 2 posedges after that coordinate is presented; pixel_on=0 whenever blank=0.
